// File: rtl/nic_host_ctrl_if.sv
// nic_host_ctrl_if: packet source/sink handshakes, NIC CPU-side port and transfer counters
interface nic_host_ctrl_if #(parameter int PACKET_WIDTH = 64);
  logic tx_valid;
  logic tx_ready;
  logic [0:PACKET_WIDTH-1] tx_data;
  logic rx_valid;
  logic rx_ready;
  logic [0:PACKET_WIDTH-1] rx_data;
  logic [0:1] addr;
  logic [0:PACKET_WIDTH-1] d_in;
  logic [0:PACKET_WIDTH-1] d_out;
  logic nicEn;
  logic nicEnWR;
  logic [15:0] tx_count;
  logic [15:0] rx_count;
  modport slave (
    input tx_valid, tx_data, rx_ready, d_out,
    output tx_ready, rx_valid, rx_data, addr, d_in, nicEn, nicEnWR, tx_count, rx_count
  );
  modport master (
    output tx_valid, tx_data, rx_ready, d_out,
    input tx_ready, rx_valid, rx_data, addr, d_in, nicEn, nicEnWR, tx_count, rx_count
  );
endinterface

// File: rtl/nic_host_ctrl.sv
// nic_host_ctrl: polls NIC status words and moves single packets between host handshakes and NIC buffers
module nic_host_ctrl #(
  parameter int PACKET_WIDTH = 64
) (
  input logic clk,
  input logic reset,
  nic_host_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, TX_STAT, TX_CHK, TX_WR, RX_STAT, RX_CHK, RX_RD, RX_CAP} state_t;
  state_t r_state, w_next;
  logic r_tx_pend, r_rx_valid, r_last_tx;
  logic [0:PACKET_WIDTH-1] r_tx_buf, r_rx_data;
  logic [15:0] r_tx_count, r_rx_count;
  logic w_full, w_tx_hs, w_rx_hs, w_set_tx, w_set_rx;
  assign w_full = bus.d_out[PACKET_WIDTH-1];
  assign w_tx_hs = bus.tx_valid && !r_tx_pend;
  assign w_rx_hs = r_rx_valid && bus.rx_ready;
  assign w_set_tx = (r_state == TX_CHK && w_full) || r_state == TX_WR;
  assign w_set_rx = (r_state == RX_CHK && !w_full) || r_state == RX_CAP;
  assign bus.tx_ready = !r_tx_pend;
  assign bus.rx_valid = r_rx_valid;
  assign bus.rx_data = r_rx_data;
  assign bus.tx_count = r_tx_count;
  assign bus.rx_count = r_rx_count;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  // when both sides are eligible, serve the one not served last
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = (r_tx_pend && (r_rx_valid || !r_last_tx)) ? TX_STAT : !r_rx_valid ? RX_STAT : IDLE;
      TX_STAT: w_next = TX_CHK;
      TX_CHK:  w_next = w_full ? IDLE : TX_WR;
      RX_STAT: w_next = RX_CHK;
      RX_CHK:  w_next = w_full ? RX_RD : IDLE;
      RX_RD:   w_next = RX_CAP;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    bus.nicEn = r_state inside {TX_STAT, TX_WR, RX_STAT, RX_RD};
    bus.nicEnWR = r_state == TX_WR;
    bus.addr = r_state == TX_STAT ? 2'b11 : r_state == TX_WR ? 2'b10 : r_state == RX_STAT ? 2'b01 : 2'b00;
    bus.d_in = r_state == TX_WR ? r_tx_buf : '0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_pend <= 1'b0;
      r_tx_buf <= '0;
      r_rx_valid <= 1'b0;
      r_rx_data <= '0;
      r_tx_count <= '0;
      r_rx_count <= '0;
      r_last_tx <= 1'b0;
    end else begin
      if (w_tx_hs) begin
        r_tx_buf <= bus.tx_data;
        r_tx_pend <= 1'b1;
      end else if (r_state == TX_WR) r_tx_pend <= 1'b0;
      if (r_state == RX_CAP) begin
        r_rx_data <= bus.d_out;
        r_rx_valid <= 1'b1;
      end else if (w_rx_hs) r_rx_valid <= 1'b0;
      r_tx_count <= r_tx_count + 16'(r_state == TX_WR);
      r_rx_count <= r_rx_count + 16'(r_state == RX_CAP);
      r_last_tx <= w_set_tx ? 1'b1 : w_set_rx ? 1'b0 : r_last_tx;
    end
  end
endmodule

// File: tb/tb_nic_host_ctrl.sv
// tb_nic_host_ctrl: behavioural NIC model plus scoreboards for written and received packets
module tb_nic_host_ctrl;
  localparam int W = 64;
  logic clk = 1'b0;
  logic reset = 1'b1;
  nic_host_ctrl_if #(.PACKET_WIDTH(W)) bus ();
  nic_host_ctrl #(.PACKET_WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int n_vec = 0, n_err = 0;
  logic [W-1:0] tx_q[$], rx_q[$], nic_in[$];
  logic [1:0] stat_log[$];
  int nic_rd = 0, polls11 = 0, busy_to = 0, n_wr = 0, m_tx = 0, m_rx = 0;
  function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction
  function automatic void fail(input string name, input string what);
    n_vec++;
    n_err++;
    $display("FAIL %s: %s", name, what);
  endfunction
  function automatic logic [0:W-1] stat(input bit full);
    logic [0:W-1] s;
    s = '0;
    s[W-1] = full;
    return s;
  endfunction
  // NIC model: answers reads one cycle later, output buffer reports full until busy_to polls have been seen
  always @(negedge clk) begin
    if (reset) begin
      tx_q.delete();
      rx_q.delete();
      nic_rd = nic_in.size();
      m_tx = 0;
      m_rx = 0;
      bus.d_out = '0;
    end else begin
      if (!bus.nicEn)
        chk("idle_port", W'(bus.nicEnWR || bus.addr != 2'b00 || bus.d_in != '0), '0);
      else if (bus.nicEnWR) begin
        n_wr++;
        m_tx++;
        chk("wr_addr", W'(bus.addr), W'(2'b10));
        if (tx_q.size() == 0) fail("wr_unexpected", $sformatf("write of %h, expected no write", bus.d_in));
        else chk("wr_data", bus.d_in, tx_q.pop_front());
      end else begin
        case (bus.addr)
          2'b11: begin
            stat_log.push_back(2'b11);
            bus.d_out = stat(polls11 < busy_to);
            polls11++;
          end
          2'b01: begin
            stat_log.push_back(2'b01);
            bus.d_out = stat(nic_rd < nic_in.size());
          end
          2'b00: begin
            chk("rd_gate", W'(bus.rx_valid), '0);
            if (nic_rd < nic_in.size()) begin
              bus.d_out = nic_in[nic_rd];
              rx_q.push_back(nic_in[nic_rd]);
              nic_rd++;
            end else fail("rd_empty", "input buffer read with no word, expected no read");
          end
          default: fail("rd_outbuf", "read of output buffer, expected none");
        endcase
      end
      if (bus.tx_valid && bus.tx_ready) tx_q.push_back(bus.tx_data);
      if (bus.rx_valid && bus.rx_ready) begin
        m_rx++;
        if (rx_q.size() == 0) fail("rx_unexpected", $sformatf("rx_data %h delivered, expected none", bus.rx_data));
        else chk("rx_data", bus.rx_data, rx_q.pop_front());
      end
    end
  end
  task automatic send(input logic [W-1:0] d);
    int t = 0;
    bus.tx_valid = 1'b1;
    bus.tx_data = d;
    @(negedge clk);
    while (!bus.tx_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) fail("send_timeout", "tx_ready stayed 0, expected 1");
    @(posedge clk);
    #1 bus.tx_valid = 1'b0;
  endtask
  task automatic wait_wr(input int target, input string name);
    int t = 0;
    while (n_wr < target && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk(name, W'(n_wr >= target), W'(1));
  endtask
  task automatic do_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int w0, p0, b, bad, lat, t;
    bus.tx_valid = 1'b0;
    bus.tx_data = '0;
    bus.rx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_port", W'(bus.nicEn || bus.nicEnWR || bus.addr != 2'b00 || bus.d_in != '0), '0);
    chk("rst_rx", W'(bus.rx_valid || bus.rx_data != '0), '0);
    chk("rst_counts", W'({bus.tx_count, bus.rx_count}), '0);
    reset = 1'b0;
    @(posedge clk);
    #1 chk("rst_tx_ready", W'(bus.tx_ready), W'(1));
    busy_to = polls11;
    w0 = n_wr;
    send(64'h200200000000FA50);
    wait_wr(w0 + 1, "single_write");
    chk("tx_count_one", W'(bus.tx_count), W'(1));
    busy_to = polls11 + 5;
    b = stat_log.size();
    p0 = polls11;
    w0 = n_wr;
    send({$urandom, $urandom});
    t = 0;
    while (n_wr == w0 && t < 300) begin
      @(posedge clk);
      #1;
      if (n_wr == w0) chk("tx_ready_busy", W'(bus.tx_ready), '0);
      t++;
    end
    repeat (8) @(posedge clk);
    #1 chk("busy_one_write", W'(n_wr - w0), W'(1));
    chk("busy_poll_count", W'(polls11 - p0), W'(6));
    bad = 0;
    for (int i = b + 1; i < stat_log.size(); i++)
      if (stat_log[i] == 2'b11 && stat_log[i-1] == 2'b11) bad++;
    chk("poll_interleave", W'(bad), '0);
    nic_in.push_back(64'h00000000DEADBEEF);
    t = 0;
    while (!bus.rx_valid && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("rx_valid_set", W'(bus.rx_valid), W'(1));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 chk("rx_hold", {bus.rx_valid ? 32'h1 : 32'h0, 32'h0} | W'(bus.rx_data), 64'h00000001DEADBEEF);
    end
    busy_to = polls11;
    w0 = n_wr;
    lat = 0;
    send({$urandom, $urandom});
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (bus.nicEnWR && lat == 0) lat = k;
    end
    chk("wr_latency", W'(lat), W'(3));
    chk("latency_write", W'(n_wr - w0), W'(1));
    bus.rx_ready = 1'b1;
    @(posedge clk);
    #1 bus.rx_ready = 1'b0;
    chk("rx_cleared", W'(bus.rx_valid), '0);
    chk("rx_count_one", W'(bus.rx_count), W'(1));
    reset = 1'b1;
    for (int i = 0; i < 3; i++) nic_in.push_back({$urandom, $urandom});
    busy_to = polls11 + 4;
    bus.rx_ready = 1'b1;
    bus.tx_valid = 1'b1;
    bus.tx_data = {$urandom, $urandom};
    b = stat_log.size();
    do_reset;
    @(posedge clk);
    #1 bus.tx_valid = 1'b0;
    t = 0;
    while (stat_log.size() < b + 10 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    bad = 0;
    for (int i = 0; i < 10; i++)
      if (stat_log.size() <= b + i || stat_log[b+i] != ((i % 2) != 0 ? 2'b11 : 2'b01)) bad++;
    chk("alternate", W'(bad), '0);
    wait_wr(n_wr + 1, "alternate_write");
    busy_to = polls11;
    send({$urandom, $urandom});
    t = 0;
    while (!bus.nicEnWR && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("reached_tx_wr", W'(bus.nicEnWR), W'(1));
    w0 = n_wr;
    reset = 1'b1;
    #1;
    chk("async_port", W'(bus.nicEn || bus.nicEnWR || bus.addr != 2'b00 || bus.d_in != '0), '0);
    chk("async_rx", W'(bus.rx_valid || bus.rx_data != '0), '0);
    chk("async_counts", W'({bus.tx_count, bus.rx_count}), '0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1 chk("post_rst_ready", W'(bus.tx_ready), W'(1));
    repeat (20) @(posedge clk);
    #1 chk("no_retry", W'(n_wr - w0), '0);
    chk("lost_uncounted", W'(bus.tx_count), '0);
    do_reset;
    fork
      for (int k = 0; k < 80; k++) begin
        repeat ($urandom_range(0, 5)) @(posedge clk);
        #1 send({$urandom, $urandom});
      end
      for (int k = 0; k < 1200; k++) begin
        @(posedge clk);
        #1 bus.rx_ready = $urandom_range(0, 2) != 0;
        if ($urandom_range(0, 11) == 0) nic_in.push_back({$urandom, $urandom});
        if ($urandom_range(0, 19) == 0) busy_to = polls11 + $urandom_range(0, 3);
      end
    join
    bus.rx_ready = 1'b1;
    busy_to = polls11;
    t = 0;
    while ((tx_q.size() != 0 || rx_q.size() != 0 || nic_rd != nic_in.size() || bus.rx_valid) && t < 1000) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drained", W'(tx_q.size() + rx_q.size() + (nic_in.size() - nic_rd)), '0);
    chk("rand_tx_count", W'(bus.tx_count), W'(16'(m_tx)));
    chk("rand_rx_count", W'(bus.rx_count), W'(16'(m_rx)));
    do_reset;
    force dut.r_tx_count = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1 release dut.r_tx_count;
    chk("preload", W'(bus.tx_count), W'(16'hFFFF));
    busy_to = polls11;
    send({$urandom, $urandom});
    wait_wr(n_wr + 1, "wrap_write");
    chk("tx_count_wrap", W'(bus.tx_count), W'(16'h0000));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
